// File: rtl/uart_cmd_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : uart_ctrl_pkg                                                |
// | Description : Shared types and constants for the UART command controller: |
// |               FSM state enum, frame opcodes and the register addresses    |
// |               that receive the ALU operands.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_ADDR  = 4'd1,
      WR_DATA  = 4'd2,
      RD_ADDR  = 4'd3,
      RD_WAIT  = 4'd4,
      ALU_A    = 4'd5,
      ALU_B    = 4'd6,
      ALU_FUN  = 4'd7,
      ALU_WAIT = 4'd8,
      TX_RD    = 4'd9,
      TX_LSB   = 4'd10,
      TX_MSB   = 4'd11
   } ctrl_state_e;

   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int unsigned OPA_ADDR = 0;
   localparam int unsigned OPB_ADDR = 1;

endpackage : uart_ctrl_pkg
`default_nettype wire

// File: rtl/uart_cmd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : uart_cmd_ctrl_if                                             |
// | Description : Bundles the RX byte stream, register-file port, ALU port    |
// |               and TX byte handshake seen by the command controller.       |
// |   master : controller side (drives WrEn/RdEn/Address/WrData, ALU_EN,       |
// |            ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD)                           |
// |   slave  : system side (drives RX_P_DATA/RX_D_VLD, RdData/RdData_Valid,    |
// |            ALU_OUT/OUT_Valid, TX_busy)                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface uart_cmd_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int FUN_W  = 4
);
   logic [DATA_W-1:0]   RX_P_DATA;
   logic                RX_D_VLD;
   logic                WrEn;
   logic                RdEn;
   logic [ADDR_W-1:0]   Address;
   logic [DATA_W-1:0]   WrData;
   logic [DATA_W-1:0]   RdData;
   logic                RdData_Valid;
   logic                ALU_EN;
   logic [FUN_W-1:0]    ALU_FUN;
   logic                CLK_EN;
   logic [2*DATA_W-1:0] ALU_OUT;
   logic                OUT_Valid;
   logic [DATA_W-1:0]   TX_P_DATA;
   logic                TX_D_VLD;
   logic                TX_busy;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_busy,
      output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_busy,
      input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
   );
endinterface : uart_cmd_ctrl_if
`default_nettype wire

// File: rtl/uart_cmd_ctrl_tx_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctrl_tx_seq                                                  |
// | Description : Returns one or two bytes to the UART transmitter, LSB first,|
// |               using a valid/busy handshake with a mandatory low cycle on  |
// |               TX_D_VLD between bytes.                                      |
// | Ports       : CLK, RST (async, active low)                                 |
// |               i_load/i_two/i_word : load 1 (i_two=0) or 2 bytes            |
// |               i_busy              : transmitter busy                       |
// |               o_data/o_vld        : byte offered to the transmitter        |
// |               o_acc               : current byte accepted this cycle       |
// |               o_done              : last byte accepted this cycle          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ctrl_tx_seq #(
   parameter int DATA_W = 8
) (
   input  wire logic                CLK,
   input  wire logic                RST,
   input  wire logic                i_load,
   input  wire logic                i_two,
   input  wire logic [2*DATA_W-1:0] i_word,
   input  wire logic                i_busy,
   output logic      [DATA_W-1:0]   o_data,
   output logic                     o_vld,
   output logic                     o_acc,
   output logic                     o_done
);
   logic              r_vld;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_msb;
   logic              r_pend;   // MSB still to be sent
   logic              r_gap;    // in the low cycle between LSB and MSB

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_vld  <= 1'b0;
         r_data <= '0;
         r_msb  <= '0;
         r_pend <= 1'b0;
         r_gap  <= 1'b0;
      end else if (i_load) begin
         r_vld  <= 1'b1;
         r_data <= i_word[DATA_W-1:0];
         r_msb  <= i_word[2*DATA_W-1:DATA_W];
         r_pend <= i_two;
         r_gap  <= 1'b0;
      end else if (r_vld && !i_busy) begin
         // Acceptance: drop valid for at least one cycle.
         r_vld <= 1'b0;
         r_gap <= r_pend;
      end else if (r_gap) begin
         r_vld  <= 1'b1;
         r_data <= r_msb;
         r_pend <= 1'b0;
         r_gap  <= 1'b0;
      end
   end

   assign o_data = r_data;
   assign o_vld  = r_vld;
   assign o_acc  = r_vld && !i_busy;
   assign o_done = r_vld && !i_busy && !r_pend;

endmodule : ctrl_tx_seq
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_cmd_ctrl                                                |
// | Description : Decodes command frames from the UART receiver, sequences    |
// |               register-file writes/reads and ALU operations, and returns  |
// |               read data / ALU results to the UART transmitter.            |
// | Ports       : CLK  - clock                                                 |
// |               RST  - asynchronous, active-low reset                        |
// |               bus  - uart_cmd_ctrl_if.master (RX, reg file, ALU, TX)       |
// | Options     : CMD_TIMEOUT_EN - abort a partial frame after TIMEOUT_CYC     |
// |               idle cycles; when undefined a partial frame waits forever.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_cmd_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int FUN_W       = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input wire logic        CLK,
   input wire logic        RST,
   uart_cmd_ctrl_if.master bus
);
   ctrl_state_e         r_state;
   ctrl_state_e         w_state_nxt;

   logic                r_wren;
   logic                r_rden;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wrdata;
   logic [FUN_W-1:0]    r_fun;

   logic                w_wren_nxt;
   logic                w_rden_nxt;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic [DATA_W-1:0]   w_wrdata_nxt;
   logic [FUN_W-1:0]    w_fun_nxt;

   logic                w_tx_load;
   logic                w_tx_two;
   logic [2*DATA_W-1:0] w_tx_word;
   logic                w_tx_acc;
   logic                w_tx_done;
   logic [DATA_W-1:0]   w_tx_data;
   logic                w_tx_vld;

   logic                w_timeout;
   logic                w_alu_en;

`ifdef CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] r_to_cnt;
   logic             w_frame_st;

   // Only states waiting for further frame bytes are supervised.
   assign w_frame_st = (r_state == WR_ADDR) || (r_state == WR_DATA) ||
                       (r_state == RD_ADDR) || (r_state == ALU_A)   ||
                       (r_state == ALU_B)   || (r_state == ALU_FUN);
   assign w_timeout  = w_frame_st && (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_to_cnt <= '0;
      end else if (!w_frame_st || bus.RX_D_VLD || w_timeout) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state and registered-output decode. Every strobe is computed here
   // and registered, so it appears the cycle after the triggering byte.
   always_comb begin
      w_state_nxt  = r_state;
      w_wren_nxt   = 1'b0;
      w_rden_nxt   = 1'b0;
      w_addr_nxt   = r_addr;
      w_wrdata_nxt = r_wrdata;
      w_fun_nxt    = r_fun;
      w_tx_load    = 1'b0;
      w_tx_two     = 1'b0;
      w_tx_word    = '0;
      case (r_state)
         IDLE: begin
            if (bus.RX_D_VLD) begin
               case (bus.RX_P_DATA)
                  DATA_W'(CMD_WR):      w_state_nxt = WR_ADDR;
                  DATA_W'(CMD_RD):      w_state_nxt = RD_ADDR;
                  DATA_W'(CMD_ALU_OP):  w_state_nxt = ALU_A;
                  DATA_W'(CMD_ALU_NOP): w_state_nxt = ALU_FUN;
                  default:              w_state_nxt = IDLE;
               endcase
            end
         end
         WR_ADDR: begin
            if (bus.RX_D_VLD) begin
               w_addr_nxt  = bus.RX_P_DATA[ADDR_W-1:0];
               w_state_nxt = WR_DATA;
            end
         end
         WR_DATA: begin
            if (bus.RX_D_VLD) begin
               w_wren_nxt   = 1'b1;
               w_wrdata_nxt = bus.RX_P_DATA;
               w_state_nxt  = IDLE;
            end
         end
         RD_ADDR: begin
            if (bus.RX_D_VLD) begin
               w_rden_nxt  = 1'b1;
               w_addr_nxt  = bus.RX_P_DATA[ADDR_W-1:0];
               w_state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (bus.RdData_Valid) begin
               w_tx_load   = 1'b1;
               w_tx_word   = {{DATA_W{1'b0}}, bus.RdData};
               w_state_nxt = TX_RD;
            end
         end
         ALU_A: begin
            if (bus.RX_D_VLD) begin
               w_wren_nxt   = 1'b1;
               w_addr_nxt   = ADDR_W'(OPA_ADDR);
               w_wrdata_nxt = bus.RX_P_DATA;
               w_state_nxt  = ALU_B;
            end
         end
         ALU_B: begin
            if (bus.RX_D_VLD) begin
               w_wren_nxt   = 1'b1;
               w_addr_nxt   = ADDR_W'(OPB_ADDR);
               w_wrdata_nxt = bus.RX_P_DATA;
               w_state_nxt  = ALU_FUN;
            end
         end
         ALU_FUN: begin
            if (bus.RX_D_VLD) begin
               w_fun_nxt   = bus.RX_P_DATA[FUN_W-1:0];
               w_state_nxt = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            if (bus.OUT_Valid) begin
               w_tx_load   = 1'b1;
               w_tx_two    = 1'b1;
               w_tx_word   = bus.ALU_OUT;
               w_state_nxt = TX_LSB;
            end
         end
         TX_RD: begin
            if (w_tx_done) begin
               w_state_nxt = IDLE;
            end
         end
         TX_LSB: begin
            if (w_tx_acc) begin
               w_state_nxt = TX_MSB;
            end
         end
         TX_MSB: begin
            if (w_tx_done) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // A byte arriving in the expiring cycle still counts as progress.
      if (w_timeout && !bus.RX_D_VLD) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= IDLE;
         r_wren   <= 1'b0;
         r_rden   <= 1'b0;
         r_addr   <= '0;
         r_wrdata <= '0;
         r_fun    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_wren   <= w_wren_nxt;
         r_rden   <= w_rden_nxt;
         r_addr   <= w_addr_nxt;
         r_wrdata <= w_wrdata_nxt;
         r_fun    <= w_fun_nxt;
      end
   end

   ctrl_tx_seq #(
      .DATA_W (DATA_W)
   ) u_tx_seq (
      .CLK    (CLK),
      .RST    (RST),
      .i_load (w_tx_load),
      .i_two  (w_tx_two),
      .i_word (w_tx_word),
      .i_busy (bus.TX_busy),
      .o_data (w_tx_data),
      .o_vld  (w_tx_vld),
      .o_acc  (w_tx_acc),
      .o_done (w_tx_done)
   );

   assign w_alu_en      = (r_state == ALU_WAIT);

   assign bus.WrEn      = r_wren;
   assign bus.RdEn      = r_rden;
   assign bus.Address   = r_addr;
   assign bus.WrData    = r_wrdata;
   assign bus.ALU_FUN   = r_fun;
   assign bus.ALU_EN    = w_alu_en;
   assign bus.CLK_EN    = w_alu_en;
   assign bus.TX_P_DATA = w_tx_data;
   assign bus.TX_D_VLD  = w_tx_vld;

endmodule : uart_cmd_ctrl
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_cmd_ctrl                                             |
// | Description : Randomized self-checking bench for uart_cmd_ctrl. A         |
// |               register-file/ALU responder and a frame-level reference    |
// |               model (expected writes, reads and TX bytes) are kept here.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_cmd_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int FW = 4;
   localparam int TO = 40;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_cmd_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .FUN_W(FW)) bus ();

   uart_cmd_ctrl #(
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .FUN_W       (FW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] q_wr[$];   // {addr, data}
   logic [3:0]  q_rd[$];
   logic [7:0]  q_tx[$];
   logic [7:0]  ref_rf[16];
   logic [7:0]  env_rf[16];
   logic [3:0]  exp_fun    = '0;
   bit          busy_force = 0;
   bit          alu_hold   = 0;
   bit          spur_en    = 0;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Arbitrary but fixed ALU behaviour used by both responder and model.
   function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
      logic [7:0] hi;
      logic [7:0] lo;
      hi = a ^ {b[6:0], 1'b0} ^ {4'h0, f};
      lo = a + b + {4'h0, f};
      return {hi, lo};
   endfunction

   // Register file / ALU / transmitter responder.
   initial begin
      int         rd_cnt = 0;
      int         alu_cnt = 0;
      bit         alu_armed = 0;
      logic [3:0] rd_a = '0;
      bus.RdData       = '0;
      bus.RdData_Valid = 1'b0;
      bus.ALU_OUT      = '0;
      bus.OUT_Valid    = 1'b0;
      bus.TX_busy      = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.RdData_Valid = 1'b0;
         bus.OUT_Valid    = 1'b0;
         bus.TX_busy      = busy_force || ($urandom_range(0, 3) == 0);
         if (!rst_n) begin
            rd_cnt = 0; alu_cnt = 0; alu_armed = 0;
            continue;
         end
         if (bus.WrEn) env_rf[bus.Address] = bus.WrData;
         if (bus.RdEn) begin
            rd_cnt = $urandom_range(1, 5);
            rd_a   = bus.Address;
         end
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               bus.RdData       = env_rf[rd_a];
               bus.RdData_Valid = 1'b1;
            end
         end else if (spur_en && !bus.RdEn && $urandom_range(0, 9) == 0) begin
            bus.RdData       = 8'($urandom);
            bus.RdData_Valid = 1'b1;
         end
         if (!bus.ALU_EN) alu_armed = 0;
         else if (!alu_armed) begin
            alu_armed = 1;
            alu_cnt   = $urandom_range(1, 5);
         end
         if (alu_cnt > 0 && !alu_hold) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
               bus.ALU_OUT   = alu_f(env_rf[0], env_rf[1], bus.ALU_FUN);
               bus.OUT_Valid = 1'b1;
            end
         end else if (spur_en && !bus.ALU_EN && $urandom_range(0, 9) == 0) begin
            bus.ALU_OUT   = 16'($urandom);
            bus.OUT_Valid = 1'b1;
         end
      end
   end

   // Monitor: sampled mid-cycle, consumes the model's expectation queues.
   initial begin
      bit          p_vld = 0;
      bit          p_busy = 0;
      bit          p_res = 0;
      logic [7:0]  p_data = '0;
      logic [11:0] w;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_vld = 0; p_busy = 0; p_res = 0;
            continue;
         end
         if (p_vld && p_busy) begin
            chk_val("tx_hold_vld", 32'(bus.TX_D_VLD), 32'd1);
            chk_val("tx_hold_data", 32'(bus.TX_P_DATA), 32'(p_data));
         end
         if (p_vld && !p_busy) chk_val("tx_gap", 32'(bus.TX_D_VLD), 32'd0);
         if (p_res) chk_val("result_latency", 32'(bus.TX_D_VLD), 32'd1);
         if (bus.WrEn) begin
            if (q_wr.size() == 0) chk_val("wr_unexpected", 32'(bus.WrEn), 32'd0);
            else begin
               w = q_wr.pop_front();
               chk_val("wr_addr", 32'(bus.Address), 32'(w[11:8]));
               chk_val("wr_data", 32'(bus.WrData), 32'(w[7:0]));
            end
         end
         if (bus.RdEn) begin
            if (q_rd.size() == 0) chk_val("rd_unexpected", 32'(bus.RdEn), 32'd0);
            else chk_val("rd_addr", 32'(bus.Address), 32'(q_rd.pop_front()));
         end
         if (bus.TX_D_VLD && !bus.TX_busy) begin
            if (q_tx.size() == 0) chk_val("tx_unexpected", 32'(bus.TX_D_VLD), 32'd0);
            else chk_val("tx_byte", 32'(bus.TX_P_DATA), 32'(q_tx.pop_front()));
         end
         if (bus.ALU_EN || bus.CLK_EN) begin
            chk_val("clk_en", 32'(bus.CLK_EN), 32'(bus.ALU_EN));
            chk_val("alu_fun", 32'(bus.ALU_FUN), 32'(exp_fun));
         end
         p_vld  = bus.TX_D_VLD;
         p_busy = bus.TX_busy;
         p_data = bus.TX_P_DATA;
         p_res  = bus.OUT_Valid && bus.ALU_EN;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.RX_P_DATA = b;
      bus.RX_D_VLD  = 1'b1;
      @(posedge clk);
      #1;
      bus.RX_D_VLD  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic rgap();
      idle($urandom_range(0, 3));
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((q_wr.size() != 0 || q_rd.size() != 0 || q_tx.size() != 0 ||
              bus.TX_D_VLD || bus.ALU_EN) && k < 400) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk_val("drain_pending", 32'(q_wr.size() + q_rd.size() + q_tx.size()), 32'd0);
      q_wr.delete(); q_rd.delete(); q_tx.delete();
      idle(2);
   endtask

   task automatic check_outputs_zero(input string pfx);
      chk_val({pfx, "_wren"},   32'(bus.WrEn),      32'd0);
      chk_val({pfx, "_rden"},   32'(bus.RdEn),      32'd0);
      chk_val({pfx, "_addr"},   32'(bus.Address),   32'd0);
      chk_val({pfx, "_wrdata"}, 32'(bus.WrData),    32'd0);
      chk_val({pfx, "_alu_en"}, 32'(bus.ALU_EN),    32'd0);
      chk_val({pfx, "_fun"},    32'(bus.ALU_FUN),   32'd0);
      chk_val({pfx, "_clk_en"}, 32'(bus.CLK_EN),    32'd0);
      chk_val({pfx, "_txdata"}, 32'(bus.TX_P_DATA), 32'd0);
      chk_val({pfx, "_txvld"},  32'(bus.TX_D_VLD),  32'd0);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      q_wr.push_back({a[3:0], d});
      ref_rf[a[3:0]] = d;
      send_byte(8'hAA); rgap();
      send_byte(a);     rgap();
      send_byte(d);
      chk_val("wr_latency", 32'(bus.WrEn), 32'd1);
      wait_drain();
   endtask

   task automatic do_read(input logic [7:0] a, input bit junk);
      q_rd.push_back(a[3:0]);
      q_tx.push_back(ref_rf[a[3:0]]);
      send_byte(8'hBB); rgap();
      send_byte(a);
      chk_val("rd_latency", 32'(bus.RdEn), 32'd1);
      if (junk) send_byte(8'hDD);
      wait_drain();
   endtask

   task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] f, input bit junk);
      logic [15:0] r;
      if (with_ops) begin
         q_wr.push_back({4'h0, a});
         q_wr.push_back({4'h1, b});
         ref_rf[0] = a;
         ref_rf[1] = b;
      end
      r = alu_f(ref_rf[0], ref_rf[1], f[3:0]);
      q_tx.push_back(r[7:0]);
      q_tx.push_back(r[15:8]);
      exp_fun = f[3:0];
      if (with_ops) begin
         send_byte(8'hCC); rgap();
         send_byte(a);     rgap();
         send_byte(b);     rgap();
      end else begin
         send_byte(8'hDD); rgap();
      end
      send_byte(f);
      chk_val("alu_latency", 32'(bus.ALU_EN), 32'd1);
      if (junk) send_byte(8'hBB);
   endtask

   initial begin
      logic [7:0] b;
      int         k;
      bus.RX_P_DATA = '0;
      bus.RX_D_VLD  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ref_rf[i] = '0;
         env_rf[i] = '0;
      end

      repeat (3) @(posedge clk);
      #2;
      check_outputs_zero("reset");
      rst_n = 1'b1;
      spur_en = 1;

      // Directed frames from the plan.
      do_write(8'h05, 8'h3C);
      do_read(8'h05, 0);
      do_alu(1, 8'h0A, 8'h03, 8'h00, 0);
      wait_drain();
      send_byte(8'h5A);
      idle(5);
      wait_drain();
      do_write(8'hF7, 8'h81);   // upper address bits ignored
      do_read(8'h27, 1);

      // Partial frame handling.
`ifdef CMD_TIMEOUT_EN
      send_byte(8'hAA); send_byte(8'h05);
      idle(TO + 5);
      do_read(8'hB5, 0);
      q_wr.push_back({4'h5, 8'h66});
      ref_rf[5] = 8'h66;
      send_byte(8'hAA); send_byte(8'h05);
      idle(TO - 10);
      send_byte(8'h66);
      chk_val("wr_before_timeout", 32'(bus.WrEn), 32'd1);
      wait_drain();
`else
      q_wr.push_back({4'h5, 8'h66});
      ref_rf[5] = 8'h66;
      send_byte(8'hAA); send_byte(8'h05);
      idle(100);
      send_byte(8'h66);
      chk_val("wr_after_wait", 32'(bus.WrEn), 32'd1);
      wait_drain();
`endif

      // Transmitter busy for 20 cycles while the LSB is offered.
      busy_force = 1;
      do_alu(0, 8'h00, 8'h00, 8'h02, 0);
      k = 0;
      while (!bus.TX_D_VLD && k < 50) begin
         @(posedge clk); #1; k++;
      end
      chk_val("busy_tx_offered", 32'(bus.TX_D_VLD), 32'd1);
      idle(20);
      busy_force = 0;
      wait_drain();

      // Reset while waiting on the ALU.
      alu_hold = 1;
      exp_fun  = 4'h9;
      send_byte(8'hDD); send_byte(8'h09);
      chk_val("alu_latency_rst", 32'(bus.ALU_EN), 32'd1);
      idle(3);
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      idle(2);
      #2;
      rst_n    = 1'b1;
      alu_hold = 0;
      idle(10);
      chk_val("post_rst_alu_en", 32'(bus.ALU_EN), 32'd0);

      // Randomized frames.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0: do_write(8'($urandom), 8'($urandom));
            1: do_read(8'($urandom), bit'($urandom_range(0, 1)));
            2: begin
               do_alu(1, 8'($urandom), 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
               wait_drain();
            end
            3: begin
               do_alu(0, 8'h00, 8'h00, 8'($urandom), bit'($urandom_range(0, 1)));
               wait_drain();
            end
            default: begin
               b = 8'($urandom);
               while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
               send_byte(b);
               idle(3);
               wait_drain();
            end
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_uart_cmd_ctrl
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

- Command controller between the UART receiver and the system core.
- Consumes deserialized bytes from the receiver and decodes multi-byte command frames.
- Sequences register-file writes and reads, and ALU operations with or without operands.
- Returns read data and ALU results to the UART transmitter as bytes, using a valid/busy handshake.

## Interface
- DATA_W, 8, byte width of RX/TX data and register data
- ADDR_W, 4, register-file address width
- FUN_W, 4, ALU function code width
- TIMEOUT_CYC, 65535, idle cycles before a partial frame is aborted (only with CMD_TIMEOUT_EN)
- CLK  in  1  single clock
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_W  received byte
- RX_D_VLD  in  1  one-cycle strobe: RX_P_DATA valid
- WrEn / RdEn  out  1  register-file write / read strobe, one cycle
- Address  out  ADDR_W  register-file address
- WrData  out  DATA_W  register-file write data
- RdData  in  DATA_W  register-file read data
- RdData_Valid  in  1  RdData valid strobe
- ALU_EN  out  1  ALU enable, held while waiting for the result
- ALU_FUN  out  FUN_W  ALU function code
- CLK_EN  out  1  ALU clock-gate enable, equal to ALU_EN
- ALU_OUT  in  2*DATA_W  ALU result
- OUT_Valid  in  1  ALU result valid strobe
- TX_P_DATA  out  DATA_W  byte to transmit
- TX_D_VLD  out  1  TX_P_DATA valid
- TX_busy  in  1  transmitter busy

## Operation
- Opcodes:
  - 0xAA write: addr, data
  - 0xBB read: addr
  - 0xCC ALU with operands: A, B, fun
  - 0xDD ALU without operands: fun
- Unknown opcode is discarded; the block stays in IDLE.
- Operands A and B are written to register addresses 0x0 and 0x1, then the ALU runs.
- Address and fun use the low ADDR_W / FUN_W bits of their bytes; upper bits are ignored.
- States and transitions, each advancing only on RX_D_VLD unless stated:
  - IDLE → WR_ADDR / RD_ADDR / ALU_A / ALU_FUN by opcode.
  - WR_ADDR → WR_DATA. On the data byte: WrEn=1 one cycle with latched Address, then → IDLE.
  - RD_ADDR: on the addr byte, RdEn=1 one cycle → RD_WAIT.
  - RD_WAIT → TX_RD on RdData_Valid; RdData is latched.
  - ALU_A: on the byte, write A to 0x0 → ALU_B.
  - ALU_B: on the byte, write B to 0x1 → ALU_FUN.
  - ALU_FUN: on the byte, latch fun → ALU_WAIT.
  - ALU_WAIT: ALU_EN=CLK_EN=1 until OUT_Valid; ALU_OUT is latched → TX_LSB.
  - TX_RD → IDLE after one byte. TX_LSB → TX_MSB → IDLE.
- Bytes arriving in RD_WAIT, ALU_WAIT or any TX state are dropped.
- A pending OUT_Valid or RdData_Valid outside its wait state is ignored.

## Timing
- All outputs reset to 0; state resets to IDLE.
- Reset mid-frame aborts the frame immediately; no further strobes are issued.
- WrEn, RdEn and operand writes occur in the cycle after the RX_D_VLD of the final byte.
- TX handshake:
  - A byte is accepted in a cycle with TX_D_VLD=1 and TX_busy=0.
  - TX_P_DATA and TX_D_VLD are held stable until accepted.
  - After each acceptance, TX_D_VLD is low for at least one cycle before the next byte.
- Latency, ALU path: final fun byte → ALU_EN high next cycle.
- Latency, result return: OUT_Valid → TX_D_VLD high next cycle.
- RX_D_VLD and OUT_Valid in the same cycle: only the one relevant to the current state is used.

## Configuration
- CMD_TIMEOUT_EN defined:
  - A counter runs in the WR_*, RD_ADDR, ALU_A, ALU_B and ALU_FUN states.
  - It is cleared on each RX_D_VLD.
  - Reaching TIMEOUT_CYC-1 returns the block to IDLE with no strobes issued.
- CMD_TIMEOUT_EN undefined:
  - No counter is built; a partial frame waits indefinitely.

## Structure
- Package uart_ctrl_pkg holds:
  - the state enum;
  - opcode constants CMD_WR, CMD_RD, CMD_ALU_OP, CMD_ALU_NOP;
  - operand addresses OPA_ADDR=0x0 and OPB_ADDR=0x1.
- Sub-module ctrl_tx_seq owns TX sequencing:
  - loads 1 or 2 bytes, LSB first;
  - runs the valid/busy handshake and gap cycle;
  - reports done to the main FSM.

## Test plan
- Write: bytes AA,05,3C → one WrEn with Address=5, WrData=3C; no TX activity.
- Read: AA,05,3C then BB,05; RdData_Valid returns 3C → TX byte 3C, then IDLE.
- ALU with operands: CC,0A,03,00; ALU_OUT=000D → writes 0A@0 and 03@1, ALU_FUN=0, TX bytes 0D then 00.
- Busy handshake: DD,02 with TX_busy held high 20 cycles → TX_D_VLD and LSB stable throughout; MSB offered only after a gap cycle.
- Error cases:
  - Unknown opcode 5A → no strobes.
  - Reset asserted in ALU_WAIT → all outputs 0, IDLE.
- Timeout (CMD_TIMEOUT_EN): AA,05, then silence for TIMEOUT_CYC cycles → IDLE, no WrEn; a following BB frame decodes normally.
